// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU mode, memory map and arbiter state definitions
package ppu_pkg;

  // PPU mode as presented on mode_in
  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAW     = 2'd3
  } ppu_state_t;

  localparam logic [15:0] OAM_LO  = 16'hFE00;
  localparam logic [15:0] OAM_HI  = 16'hFE9F;
  localparam logic [15:0] VRAM_LO = 16'h8000;
  localparam logic [15:0] VRAM_HI = 16'h9FFF;

  // clocks a read may wait for mem_data_valid_in before 8'hFF is returned
  localparam int TIMEOUT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_PPU_RD = 2'd1,
    ARB_CPU_RD = 2'd2,
    ARB_CPU_WR = 2'd3
  } arb_state_t;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/ppu_cpu_lock.sv
// rtl/ppu_cpu_lock.sv - CPU access lockout decoder for OAM and VRAM
// Ports:
//   addr    CPU address being decoded
//   mode    current PPU mode
//   lcd_en  LCDC[7]; lockout only applies while the LCD is on
//   locked  1 when the CPU must not touch this address in this mode
module ppu_cpu_lock
  import ppu_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [1:0]  mode,
  input  logic        lcd_en,
  output logic        locked
);

  ppu_state_t ppu_mode;
  logic       oam_hit;
  logic       vram_hit;

  always_comb begin
    ppu_mode = ppu_state_t'(mode);
    oam_hit  = in_range(addr, OAM_LO, OAM_HI);
    vram_hit = in_range(addr, VRAM_LO, VRAM_HI);
    locked   = lcd_en &&
               ((oam_hit  && (ppu_mode == OAM_SCAN || ppu_mode == DRAW)) ||
                (vram_hit && (ppu_mode == DRAW)));
  end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// rtl/ppu_mem_arbiter.sv - VRAM/OAM port arbiter between PPU fetch and CPU
// Ports:
//   clk_in, rst_in, tclk_in           clock, sync active-high reset, T-cycle enable
//   mode_in, lcd_en_in                PPU mode and LCD enable for lockout
//   ppu_addr_in/_valid_in             PPU read request (level)
//   ppu_data_out/_valid_out           PPU read data, one-clk valid
//   cpu_addr/wdata/we/req_in          CPU request, held until cpu_ready_out
//   cpu_ready_out                     one-clk accept pulse
//   cpu_rdata_out/_valid_out          CPU read data, one-clk valid
//   mem_addr/wdata/we/req_out         memory request, one-clk pulse
//   mem_data_in/_valid_in             memory read return
//   blocked_count_out                 saturating count of locked CPU accesses
module ppu_mem_arbiter
  import ppu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  mode_in,
  input  logic        lcd_en_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_addr_valid_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  input  logic        cpu_we_in,
  input  logic        cpu_req_in,
  output logic        cpu_ready_out,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_rdata_valid_out,
  output logic [15:0] mem_addr_out,
  output logic [7:0]  mem_wdata_out,
  output logic        mem_we_out,
  output logic        mem_req_out,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_data_valid_in,
  output logic [15:0] blocked_count_out
);

  arb_state_t  state_q, state_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        blk_rd_q, blk_rd_d;   // locked CPU read owes an 8'hFF next clk
  logic        cpu_locked;

  logic [15:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic        mem_we_d, mem_req_d;
  logic        cpu_ready_d;
  logic [7:0]  cpu_rdata_d, ppu_data_d, rd_data;
  logic        cpu_valid_d, ppu_valid_d;
  logic [15:0] blocked_d;

  ppu_cpu_lock u_lock (
    .addr   (cpu_addr_in),
    .mode   (mode_in),
    .lcd_en (lcd_en_in),
    .locked (cpu_locked)
  );

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    blk_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_out;
    mem_wdata_d = mem_wdata_out;
    mem_we_d    = 1'b0;
    mem_req_d   = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_out;
    cpu_valid_d = 1'b0;
    ppu_data_d  = ppu_data_out;
    ppu_valid_d = 1'b0;
    blocked_d   = blocked_count_out;
    rd_data     = mem_data_valid_in ? mem_data_in : 8'hFF;

    if (blk_rd_q) begin
      cpu_rdata_d = 8'hFF;
      cpu_valid_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        tmo_d = '0;
        if (tclk_in) begin
          if (ppu_addr_valid_in) begin
            mem_req_d  = 1'b1;
            mem_addr_d = ppu_addr_in;
            state_d    = ARB_PPU_RD;
          // cpu_ready_out high means the held request was just accepted;
          // do not serve it a second time in its accept cycle
          end else if (cpu_req_in && !cpu_ready_out) begin
            cpu_ready_d = 1'b1;
            if (cpu_locked) begin
              if (blocked_count_out != 16'hFFFF)
                blocked_d = blocked_count_out + 16'd1;
              blk_rd_d = !cpu_we_in;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = cpu_we_in;
              mem_addr_d  = cpu_addr_in;
              mem_wdata_d = cpu_wdata_in;
              state_d     = cpu_we_in ? ARB_CPU_WR : ARB_CPU_RD;
            end
          end
        end
      end
      ARB_CPU_WR: state_d = ARB_IDLE;
      ARB_PPU_RD, ARB_CPU_RD: begin
        if (mem_data_valid_in || tmo_q == 4'(TIMEOUT - 1)) begin
          if (state_q == ARB_PPU_RD) begin
            ppu_data_d  = rd_data;
            ppu_valid_d = 1'b1;
          end else begin
            cpu_rdata_d = rd_data;
            cpu_valid_d = 1'b1;
          end
          tmo_d   = '0;
          state_d = ARB_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q             <= ARB_IDLE;
      tmo_q               <= '0;
      blk_rd_q            <= 1'b0;
      mem_addr_out        <= '0;
      mem_wdata_out       <= '0;
      mem_we_out          <= 1'b0;
      mem_req_out         <= 1'b0;
      cpu_ready_out       <= 1'b0;
      cpu_rdata_out       <= 8'h00;
      cpu_rdata_valid_out <= 1'b0;
      ppu_data_out        <= 8'h00;
      ppu_data_valid_out  <= 1'b0;
      blocked_count_out   <= '0;
    end else begin
      state_q             <= state_d;
      tmo_q               <= tmo_d;
      blk_rd_q            <= blk_rd_d;
      mem_addr_out        <= mem_addr_d;
      mem_wdata_out       <= mem_wdata_d;
      mem_we_out          <= mem_we_d;
      mem_req_out         <= mem_req_d;
      cpu_ready_out       <= cpu_ready_d;
      cpu_rdata_out       <= cpu_rdata_d;
      cpu_rdata_valid_out <= cpu_valid_d;
      ppu_data_out        <= ppu_data_d;
      ppu_data_valid_out  <= ppu_valid_d;
      blocked_count_out   <= blocked_d;
    end
  end

endmodule
